reg_file_sb: RTL
================

# reg_file_sb

Parametrised multi-lane register file with built-in write-to-read forwarding and a per-register busy scoreboard for the superscalar MIPS core. It generalises the dual-issue, two-write-port register file to LANES issue lanes, with configurable data width and register count. Decode reads operands and busy status here, and writeback writes results here. Issue marks destinations busy so decode can detect RAW hazards without an external scoreboard.

## Interface
Parameters:
- DATA_W, 32, data width per register
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- LANES, 2, number of issue lanes; each lane has 2 read ports, 1 write port and 1 issue port

Ports (lane i occupies bits [i*W +: W] of each flattened vector):
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all registers and scoreboard
- A1  input  LANES*ADDR_W  first read address per lane
- A2  input  LANES*ADDR_W  second read address per lane
- RD1  output  LANES*DATA_W  data for A1 (combinational)
- RD2  output  LANES*DATA_W  data for A2 (combinational)
- BUSY1  output  LANES  A1 has an outstanding producer
- BUSY2  output  LANES  A2 has an outstanding producer
- WE  input  LANES  writeback enable per lane
- WA  input  LANES*ADDR_W  writeback address per lane
- WD  input  LANES*DATA_W  writeback data per lane
- ISE  input  LANES  issue enable; marks destination busy
- ISA  input  LANES*ADDR_W  issued destination address per lane

## Operation
- Register 0 always reads 0 and is never busy. Writes and issues to address 0 are ignored.
- Write: for WE[i] and WA[i]≠0, reg[WA[i]] ← WD[i] at the rising edge.
- Same-address write conflict: the highest-numbered lane wins, because the higher lane holds the younger instruction.
- Forwarding: if any lane writes address a this cycle (a≠0), a read of a returns that lane's WD instead of stored data. With multiple such writers, the value comes from the highest writing lane. Otherwise the read returns reg[a].
- Scoreboard sb[2**ADDR_W] is updated every edge:
  - a bit is cleared by any enabled write to it;
  - a bit is set by any enabled issue to it;
  - if set and clear hit the same register in the same cycle, set wins, since the new producer is outstanding.
- BUSYk[i] = sb[Ak[i]] AND NOT (some lane writes Ak[i] this cycle). A result arriving this cycle is forwarded, so the operand is not treated as busy.
- Issue lanes are independent of read lanes. The block does no hazard stalling itself.

## Timing
- Reads and BUSY are combinational, with zero-cycle latency. Forwarding is in the same cycle.
- A write or issue becomes visible in stored state on the cycle after the edge.
- Reset asserted:
  - all registers and all sb bits clear asynchronously;
  - RD outputs read 0 (forwarding is suppressed), and BUSY reads 0;
  - a write or issue coinciding with the edge where Reset is high is discarded.
- After Reset deasserts, the first edge performs normal updates.
- X on WE or ISE during Reset must not corrupt state.

## Structure
- Package reg_file_pkg holds:
  - default DATA_W, ADDR_W and LANES constants;
  - ZERO_REG = 0;
  - the lane slice helper, as a width-parametrised localparam convention.
- Sub-module reg_file_fwd: one per read port (2*LANES instances). It takes the read address, the stored data word and all lanes' WE/WA/WD, and produces forwarded data plus a "written-this-cycle" flag used to mask BUSY.
- Target size: about 200 RTL lines in total.

## Test plan
- Reset then readback:
  - Reset for 1 cycle, then read all 32 addresses -> every RD = 0 and every BUSY = 0.
  - Write R1=32'h6969ffff (lane 0) and R2=32'haaaaaaaa (lane 1), then read next cycle -> RD1[0]=6969ffff, RD2[0]=aaaaaaaa.
- Forwarding: in one cycle, write R3=32'h42042069 on lane 0 while A1[1]=3 -> RD1[1]=42042069 in the same cycle.
- Write conflict: lanes 0 and 1 both write R4, with 11111111 on lane 0 and 33229999 on lane 1 -> forwarded value and stored value next cycle are both 33229999.
- Register zero: write R0=deadbeef and issue R0 -> RD of R0 = 0 and BUSY = 0, before and after the edge.
- Scoreboard:
  - Issue R5, then next cycle read R5 -> BUSY=1.
  - Write R5=00000005 while reading R5 -> BUSY=0 and RD=5.
  - Issue and write R5 in the same cycle -> BUSY=1 next cycle.
- Async reset mid-operation: assert Reset between edges with WE=x and data pending -> outputs go to 0 immediately, and R1..R5 read 0 after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and the lane-slicing helper for the multi-lane register file.
package reg_file_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_LANES  = 2;
  localparam int ZERO_REG   = 0;

  // Lane i of a flattened per-lane vector of width w starts at bit i*w
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/reg_file_fwd.sv
// One read port's forwarding mux: picks the youngest same-cycle write to the
// read address, otherwise the stored word. hit masks the busy bit.
module reg_file_fwd
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       stored,
  input  logic [LANES-1:0]        we,
  input  logic [LANES*ADDR_W-1:0] wa,
  input  logic [LANES*DATA_W-1:0] wd,
  output logic [DATA_W-1:0]       data,
  output logic                    hit
);
  // Ascending lane scan so the highest (youngest) writing lane wins
  always_comb begin
    data = stored;
    hit  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (we[l] && (addr != ADDR_W'(ZERO_REG)) &&
          (wa[lane_lsb(l, ADDR_W) +: ADDR_W] == addr)) begin
        data = wd[lane_lsb(l, DATA_W) +: DATA_W];
        hit  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-lane register file with same-cycle write forwarding and a per-register
// busy scoreboard (issue sets, writeback clears, set wins on collision).
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [LANES*ADDR_W-1:0] A1,
  input  logic [LANES*ADDR_W-1:0] A2,
  output logic [LANES*DATA_W-1:0] RD1,
  output logic [LANES*DATA_W-1:0] RD2,
  output logic [LANES-1:0]        BUSY1,
  output logic [LANES-1:0]        BUSY2,
  input  logic [LANES-1:0]        WE,
  input  logic [LANES*ADDR_W-1:0] WA,
  input  logic [LANES*DATA_W-1:0] WD,
  input  logic [LANES-1:0]        ISE,
  input  logic [LANES*ADDR_W-1:0] ISA
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             sb_q, sb_d;

  // Next state: youngest lane's write lands last; scoreboard clears before sets
  always_comb begin
    regs_d = regs_q;
    sb_d   = sb_q;
    for (int l = 0; l < LANES; l++) begin
      if (WE[l] && (WA[lane_lsb(l, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
        regs_d[WA[lane_lsb(l, ADDR_W) +: ADDR_W]] = WD[lane_lsb(l, DATA_W) +: DATA_W];
        sb_d[WA[lane_lsb(l, ADDR_W) +: ADDR_W]]   = 1'b0;
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (ISE[l] && (ISA[lane_lsb(l, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_REG)))
        sb_d[ISA[lane_lsb(l, ADDR_W) +: ADDR_W]] = 1'b1;
    end
  end

  // State registers; reset dominates so X on enables during reset is harmless
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs_q <= '0;
      sb_q   <= '0;
    end else begin
      regs_q <= regs_d;
      sb_q   <= sb_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ADDR_W-1:0] a1, a2;
    logic [DATA_W-1:0] d1, d2;
    logic              h1, h2;

    assign a1 = A1[i*ADDR_W +: ADDR_W];
    assign a2 = A2[i*ADDR_W +: ADDR_W];

    reg_file_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) u_fwd1 (
      .addr(a1), .stored(regs_q[a1]), .we(WE), .wa(WA), .wd(WD),
      .data(d1), .hit(h1)
    );
    reg_file_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) u_fwd2 (
      .addr(a2), .stored(regs_q[a2]), .we(WE), .wa(WA), .wd(WD),
      .data(d2), .hit(h2)
    );

    // Reset forces quiet outputs; a result arriving now is forwarded, not busy
    assign RD1[i*DATA_W +: DATA_W] = Reset ? '0 : d1;
    assign RD2[i*DATA_W +: DATA_W] = Reset ? '0 : d2;
    assign BUSY1[i] = !Reset && sb_q[a1] && !h1;
    assign BUSY2[i] = !Reset && sb_q[a2] && !h2;
  end
endmodule
